// File: rtl/evict_wb_buffer.sv
// -----------------------------------------------------------------------------
// evict_wb_buffer
//
// Dirty-victim writeback buffer behind the fully associative cache array.
// Up to IN_PORT_NUM evicted lines arrive per cycle. Clean victims are dropped.
// Dirty victims are queued in FIFO order in a circular buffer. They drain to
// memory through a valid/ready write request. Read ports let a cache miss find
// a line that is still waiting in the buffer.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   evict[i]             eviction valid on port i (port 0 oldest in a cycle)
//   evicted_addr/data    victim line address / data per port
//   evicted_dirty[i]     victim dirty flag; clean victims are discarded
//   in_ready             room for IN_PORT_NUM victims (registered count only)
//   mem_req_valid/addr/data, mem_req_ready
//                        head-of-queue write request handshake
//   rd_addr[r]           lookup address
//   rd_hit[r], rd_data[r] lookup result; youngest match wins, data 0 on miss
//   count, empty, full   occupancy status
//
// Build option
//   WB_COALESCE_EN       When defined, a dirty victim that matches a valid
//                        non-head entry overwrites that entry's data instead of
//                        allocating. Same-cycle duplicates collapse into one
//                        entry, and the higher port's data is kept.
// -----------------------------------------------------------------------------
module evict_wb_buffer #(
    parameter int IN_PORT_NUM = 2,
    parameter int RD_PORT_NUM = 2,
    parameter int ADDR_WIDTH  = 13,
    parameter int DATA_WIDTH  = 64,
    parameter int DEPTH       = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [IN_PORT_NUM-1:0]                  evict,
    input  logic [IN_PORT_NUM-1:0][ADDR_WIDTH-1:0]  evicted_addr,
    input  logic [IN_PORT_NUM-1:0][DATA_WIDTH-1:0]  evicted_data,
    input  logic [IN_PORT_NUM-1:0]                  evicted_dirty,
    output logic                                    in_ready,
    output logic                                    mem_req_valid,
    output logic [ADDR_WIDTH-1:0]                   mem_req_addr,
    output logic [DATA_WIDTH-1:0]                   mem_req_data,
    input  logic                                    mem_req_ready,
    input  logic [RD_PORT_NUM-1:0][ADDR_WIDTH-1:0]  rd_addr,
    output logic [RD_PORT_NUM-1:0]                  rd_hit,
    output logic [RD_PORT_NUM-1:0][DATA_WIDTH-1:0]  rd_data,
    output logic [$clog2(DEPTH+1)-1:0]              count,
    output logic                                    empty,
    output logic                                    full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]                 head_q, head_d;
    logic [PTR_W-1:0]                 tail_q, tail_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_mem_q, addr_mem_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_mem_q, data_mem_d;

    logic             pop;
    logic             merged;
    int               n_new;
    logic [PTR_W-1:0] lk_slot;
`ifdef WB_COALESCE_EN
    logic [PTR_W-1:0] slot;
    logic [PTR_W-1:0] merge_slot;
`endif

    // Status and the memory request depend only on registered state.
    assign count         = count_q;
    assign empty         = (count_q == '0);
    assign full          = (count_q == CNT_W'(DEPTH));
    assign in_ready      = (int'(count_q) <= (DEPTH - IN_PORT_NUM));
    assign mem_req_valid = !empty;
    assign mem_req_addr  = mem_req_valid ? addr_mem_q[head_q] : '0;
    assign mem_req_data  = mem_req_valid ? data_mem_q[head_q] : '0;
    assign pop           = mem_req_valid & mem_req_ready;

    // Enqueue / coalesce / dequeue next state.
    always_comb begin
        // NOTE: blocking assignments are used here on purpose. Each port sees
        // the tail and memory contents left by the lower ports in this cycle,
        // so same-cycle victims are written in ascending port order.
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        tail_d     = tail_q;
        n_new      = 0;
        merged     = 1'b0;
`ifdef WB_COALESCE_EN
        slot       = '0;
        merge_slot = '0;
`endif
        for (int p = 0; p < IN_PORT_NUM; p++) begin
            if (evict[p] && evicted_dirty[p] && in_ready) begin
                merged = 1'b0;
`ifdef WB_COALESCE_EN
                // A merge target is any occupied entry except the existing head,
                // which is on the memory bus and must stay stable. Entries
                // allocated earlier in this cycle are also targets. The last
                // match found is the youngest one.
                for (int k = 0; k < DEPTH; k++) begin
                    slot = head_q + PTR_W'(k);
                    if ((k < int'(count_q) + n_new) && (k != 0 || count_q == '0) &&
                        (addr_mem_d[slot] == evicted_addr[p])) begin
                        merged     = 1'b1;
                        merge_slot = slot;
                    end
                end
                if (merged) begin
                    data_mem_d[merge_slot] = evicted_data[p];
                end
`endif
                if (!merged) begin
                    addr_mem_d[tail_d] = evicted_addr[p];
                    data_mem_d[tail_d] = evicted_data[p];
                    tail_d             = tail_d + PTR_W'(1);
                    n_new              = n_new + 1;
                end
            end
        end
        head_d  = head_q + PTR_W'(pop);
        count_d = CNT_W'(int'(count_q) + n_new - (pop ? 1 : 0));
    end

    // Associative lookup. Entries are scanned from the head toward the tail,
    // so the youngest match is written last. The popping head still counts as
    // occupied this cycle.
    always_comb begin
        // NOTE: every output gets a default before the loop. Otherwise a miss
        // would leave rd_hit/rd_data unassigned on that path and infer a latch.
        rd_hit  = '0;
        rd_data = '0;
        lk_slot = '0;
        for (int r = 0; r < RD_PORT_NUM; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                lk_slot = head_q + PTR_W'(k);
                if ((k < int'(count_q)) && (addr_mem_q[lk_slot] == rd_addr[r])) begin
                    rd_hit[r]  = 1'b1;
                    rd_data[r] = data_mem_q[lk_slot];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the line storage is not reset. An entry is meaningful only while
    // it lies inside the head..count window, and clearing count clears that
    // window.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

endmodule

// File: tb/tb_evict_wb_buffer.sv
// -----------------------------------------------------------------------------
// tb_evict_wb_buffer
//
// Self-checking bench for evict_wb_buffer. A queue-based reference model holds
// the buffered lines in drain order. It predicts occupancy, the head request and
// lookup results. Directed scenarios cover reset, clean drop, fill/drain,
// youngest-match lookup and reset mid-drain. Coalescing is covered when
// WB_COALESCE_EN is defined. A randomized run follows.
// -----------------------------------------------------------------------------
module tb_evict_wb_buffer;

    localparam int IN_N  = 2;
    localparam int RD_N  = 2;
    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic                     clk;
    logic                     rst;
    logic [IN_N-1:0]          evict;
    logic [IN_N-1:0][AW-1:0]  evicted_addr;
    logic [IN_N-1:0][DW-1:0]  evicted_data;
    logic [IN_N-1:0]          evicted_dirty;
    logic                     in_ready;
    logic                     mem_req_valid;
    logic [AW-1:0]            mem_req_addr;
    logic [DW-1:0]            mem_req_data;
    logic                     mem_req_ready;
    logic [RD_N-1:0][AW-1:0]  rd_addr;
    logic [RD_N-1:0]          rd_hit;
    logic [RD_N-1:0][DW-1:0]  rd_data;
    logic [2:0]               count;
    logic                     empty;
    logic                     full;

    int vectors     = 0;
    int miscompares = 0;

    ent_t mq[$];

    evict_wb_buffer #(
        .IN_PORT_NUM(IN_N), .RD_PORT_NUM(RD_N), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .evict(evict), .evicted_addr(evicted_addr), .evicted_data(evicted_data),
        .evicted_dirty(evicted_dirty), .in_ready(in_ready),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit model_ready();
        return (DEPTH - mq.size()) >= IN_N;
    endfunction

    function automatic void model_lookup(input logic [AW-1:0] a, output logic hit,
                                         output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (mq[i]) if (mq[i].addr == a) begin hit = 1'b1; d = mq[i].data; end
    endfunction

    // Applies the current inputs to the model exactly as the coming edge will.
    task automatic model_edge();
        int   old;
        bit   do_pop;
        bit   rdy;
        ent_t e;
        if (rst) begin
            mq.delete();
            return;
        end
        old    = mq.size();
        do_pop = (old != 0) && mem_req_ready;
        rdy    = model_ready();
        for (int p = 0; p < IN_N; p++) begin
            if (evict[p] && evicted_dirty[p] && rdy) begin
                int hit_idx;
                hit_idx = -1;
`ifdef WB_COALESCE_EN
                foreach (mq[i]) if ((i >= 1 || old == 0) && mq[i].addr == evicted_addr[p]) hit_idx = i;
`endif
                if (hit_idx >= 0) mq[hit_idx].data = evicted_data[p];
                else begin
                    e.addr = evicted_addr[p];
                    e.data = evicted_data[p];
                    mq.push_back(e);
                end
            end
        end
        if (do_pop) void'(mq.pop_front());
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        evict         = '0;
        evicted_dirty = '0;
        evicted_addr  = '0;
        evicted_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input int p, input logic dirty, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        evict[p]         = 1'b1;
        evicted_dirty[p] = dirty;
        evicted_addr[p]  = a;
        evicted_data[p]  = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        rd_addr[0] = 13'h012;
        rd_addr[1] = 13'h000;
        #1;
        vectors += 8;
        if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); end
        if (mem_req_addr !== '0 || mem_req_data !== '0) begin
            miscompares++; $display("FAIL reset_mem_payload: got %h/%h want 0/0", mem_req_addr, mem_req_data);
        end
        if (rd_hit !== 2'b00) begin miscompares++; $display("FAIL reset_rd_hit: got %b want 00", rd_hit); end
        if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    endtask

    task automatic test_single_enqueue();
        do_reset();
        drive(0, 1'b1, 13'h012, 64'hA5A5);
        tick();
        idle_inputs();
        rd_addr[0] = 13'h012;
        rd_addr[1] = 13'h099;
        #1;
        vectors += 6;
        if (count !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", count); end
        if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", mem_req_valid); end
        if (mem_req_addr !== 13'h012) begin miscompares++; $display("FAIL single_addr: got %h want 012", mem_req_addr); end
        if (mem_req_data !== 64'hA5A5) begin miscompares++; $display("FAIL single_data: got %h want a5a5", mem_req_data); end
        if (rd_hit[0] !== 1'b1 || rd_data[0] !== 64'hA5A5) begin
            miscompares++; $display("FAIL single_lookup_hit: got %b/%h want 1/a5a5", rd_hit[0], rd_data[0]);
        end
        if (rd_hit[1] !== 1'b0 || rd_data[1] !== '0) begin
            miscompares++; $display("FAIL single_lookup_miss: got %b/%h want 0/0", rd_hit[1], rd_data[1]);
        end
    endtask

    task automatic test_clean_drop();
        do_reset();
        drive(0, 1'b0, 13'h020, 64'h20);
        drive(1, 1'b1, 13'h021, 64'h21);
        tick();
        idle_inputs();
        vectors += 2;
        if (count !== 3'd1) begin miscompares++; $display("FAIL clean_count: got %0d want 1", count); end
        if (mem_req_addr !== 13'h021) begin miscompares++; $display("FAIL clean_head: got %h want 021", mem_req_addr); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            drive(0, 1'b1, AW'(13'h100 + 2 * c), DW'(64'h1100 + 2 * c));
            drive(1, 1'b1, AW'(13'h101 + 2 * c), DW'(64'h1101 + 2 * c));
            tick();
        end
        idle_inputs();
        vectors += 3;
        if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d want 4", count); end
        if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        // Deliberate protocol error: eviction while not ready must be ignored.
        $display("note: protocol error injected (evict while in_ready=0)");
        drive(0, 1'b1, 13'h1FF, 64'hDEAD);
        drive(1, 1'b1, 13'h1FE, 64'hBEEF);
        tick();
        idle_inputs();
        rd_addr[0] = 13'h1FF;
        rd_addr[1] = 13'h1FE;
        #1;
        vectors += 2;
        if (count !== 3'd4) begin miscompares++; $display("FAIL ignored_evict_count: got %0d want 4", count); end
        if (rd_hit !== 2'b00) begin miscompares++; $display("FAIL ignored_evict_hit: got %b want 00", rd_hit); end
        mem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== AW'(13'h100 + i) || mem_req_data !== DW'(64'h1100 + i)) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: got v=%b %h/%h want v=1 %h/%h", i, mem_req_valid,
                         mem_req_addr, mem_req_data, AW'(13'h100 + i), DW'(64'h1100 + i));
            end
            tick();
        end
        mem_req_ready = 1'b0;
        vectors++;
        if (empty !== 1'b1 || mem_req_valid !== 1'b0) begin
            miscompares++; $display("FAIL drain_empty: got empty=%b valid=%b want 1/0", empty, mem_req_valid);
        end
    endtask

    task automatic test_steady_state();
        bit saw_drop;
        saw_drop = 1'b0;
        do_reset();
        mem_req_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            vectors += 3;
            if (count !== 3'(mq.size())) begin miscompares++; $display("FAIL steady_count[%0d]: got %0d want %0d", c, count, mq.size()); end
            if (in_ready !== model_ready()) begin miscompares++; $display("FAIL steady_in_ready[%0d]: got %b want %b", c, in_ready, model_ready()); end
            if (mq.size() != 0 && (mem_req_addr !== mq[0].addr || mem_req_data !== mq[0].data)) begin
                miscompares++;
                $display("FAIL steady_head[%0d]: got %h/%h want %h/%h", c, mem_req_addr, mem_req_data, mq[0].addr, mq[0].data);
            end
            if (mq.size() == 3 && in_ready === 1'b0) saw_drop = 1'b1;
            idle_inputs();
            if (model_ready()) begin
                drive(0, 1'b1, AW'($urandom), {$urandom, $urandom});
                drive(1, 1'b1, AW'($urandom), {$urandom, $urandom});
            end
            tick();
        end
        idle_inputs();
        mem_req_ready = 1'b0;
        vectors++;
        if (!saw_drop) begin miscompares++; $display("FAIL steady_ready_drop: got no drop at count 3, want drop"); end
    endtask

    task automatic test_youngest_lookup();
        do_reset();
        drive(0, 1'b1, 13'h040, 64'd1);
        tick();
        drive(0, 1'b1, 13'h040, 64'd2);
        tick();
        idle_inputs();
        rd_addr[0] = 13'h040;
        rd_addr[1] = 13'h041;
        #1;
        vectors += 3;
        if (count !== 3'd2) begin miscompares++; $display("FAIL dup_count: got %0d want 2", count); end
        if (rd_hit[0] !== 1'b1 || rd_data[0] !== 64'd2) begin
            miscompares++; $display("FAIL dup_youngest: got %b/%0d want 1/2", rd_hit[0], rd_data[0]);
        end
        if (rd_hit[1] !== 1'b0) begin miscompares++; $display("FAIL dup_miss: got %b want 0", rd_hit[1]); end
        mem_req_ready = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            vectors++;
            if (mem_req_addr !== 13'h040 || mem_req_data !== DW'(i)) begin
                miscompares++; $display("FAIL dup_drain[%0d]: got %h/%0d want 040/%0d", i, mem_req_addr, mem_req_data, i);
            end
            tick();
        end
        mem_req_ready = 1'b0;
        vectors++;
        if (empty !== 1'b1) begin miscompares++; $display("FAIL dup_empty: got %b want 1", empty); end
    endtask

`ifdef WB_COALESCE_EN
    task automatic test_coalesce();
        do_reset();
        drive(0, 1'b1, 13'h050, 64'd5);
        tick();
        drive(0, 1'b1, 13'h060, 64'd7);
        tick();
        drive(0, 1'b1, 13'h060, 64'd9);
        tick();
        idle_inputs();
        vectors += 3;
        if (count !== 3'd2) begin miscompares++; $display("FAIL coal_count: got %0d want 2", count); end
        if (mem_req_addr !== 13'h050) begin miscompares++; $display("FAIL coal_head0: got %h want 050", mem_req_addr); end
        mem_req_ready = 1'b1;
        tick();
        if (mem_req_addr !== 13'h060 || mem_req_data !== 64'd9) begin
            miscompares++; $display("FAIL coal_head1: got %h/%0d want 060/9", mem_req_addr, mem_req_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_req_ready = 1'b0;
        vectors += 2;
        if (count !== 3'd0) begin miscompares++; $display("FAIL coal_rst_count: got %0d want 0", count); end
        if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL coal_rst_valid: got %b want 0", mem_req_valid); end
    endtask
`endif

    task automatic test_rst_mid_drain();
        do_reset();
        drive(0, 1'b1, 13'h070, 64'h70);
        drive(1, 1'b1, 13'h071, 64'h71);
        tick();
        idle_inputs();
        drive(0, 1'b1, 13'h072, 64'h72);
        tick();
        idle_inputs();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_addr[0] = 13'h071;
        rd_addr[1] = 13'h072;
        #1;
        vectors += 3;
        if (count !== 3'd0 || empty !== 1'b1) begin
            miscompares++; $display("FAIL rst_drain_count: got %0d/%b want 0/1", count, empty);
        end
        if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_drain_valid: got %b want 0", mem_req_valid); end
        if (rd_hit !== 2'b00) begin miscompares++; $display("FAIL rst_drain_hit: got %b want 00", rd_hit); end
    endtask

    task automatic test_random();
        logic          exp_hit;
        logic [DW-1:0] exp_data;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < RD_N; r++) rd_addr[r] = AW'(13'h300 + $urandom_range(0, 7));
            #1;
            vectors += 4;
            if (count !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
                miscompares++;
                $display("FAIL rand_status[%0d]: got cnt=%0d e=%b f=%b want cnt=%0d", c, count, empty, full, mq.size());
            end
            if (in_ready !== model_ready()) begin
                miscompares++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, model_ready());
            end
            if (mem_req_valid !== (mq.size() != 0)) begin
                miscompares++; $display("FAIL rand_valid[%0d]: got %b want %b", c, mem_req_valid, mq.size() != 0);
            end
            if (mq.size() != 0 && (mem_req_addr !== mq[0].addr || mem_req_data !== mq[0].data)) begin
                miscompares++;
                $display("FAIL rand_head[%0d]: got %h/%h want %h/%h", c, mem_req_addr, mem_req_data, mq[0].addr, mq[0].data);
            end
            for (int r = 0; r < RD_N; r++) begin
                model_lookup(rd_addr[r], exp_hit, exp_data);
                vectors++;
                if (rd_hit[r] !== exp_hit || rd_data[r] !== exp_data) begin
                    miscompares++;
                    $display("FAIL rand_lookup[%0d][%0d]: got %b/%h want %b/%h", c, r, rd_hit[r], rd_data[r], exp_hit, exp_data);
                end
            end
            idle_inputs();
            mem_req_ready = ($urandom_range(0, 2) != 0);
            if (model_ready()) begin
                for (int p = 0; p < IN_N; p++) begin
                    if ($urandom_range(0, 1) == 1)
                        drive(p, ($urandom_range(0, 3) != 0), AW'(13'h300 + $urandom_range(0, 7)), {$urandom, $urandom});
                end
            end
            tick();
        end
        idle_inputs();
        mem_req_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_req_ready = 1'b0;
        rd_addr = '0;
        idle_inputs();
        test_reset();
        test_single_enqueue();
        test_clean_drop();
        test_fill_drain();
        test_steady_state();
        test_youngest_lookup();
`ifdef WB_COALESCE_EN
        test_coalesce();
`endif
        test_rst_mid_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
